// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
package sram_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Port 1 behaviour when it reads the word port 0 is writing in the same cycle.
  localparam int COLL_OLD = 0;
  localparam int COLL_NEW = 1;

  // Widest word the lane-merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH = 512;

  // Replace every lane of old_word whose mask bit is set with the same lane of new_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] mask,
    input int                        lane_width
  );
    logic [MAX_DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (mask[i / lane_width]) r[i] = new_word[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline for one SRAM port: captures the word on the request
// edge, optionally adds one more register stage, and holds the last word.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  coll_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic                  coll
);

  logic [DATA_WIDTH-1:0] d1;
  logic                  v1;
  logic                  c1;

  // First stage: latch the array word only when a read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      v1 <= req;
      c1 <= req & coll_in;
      if (req) d1 <= data_in;
    end
  end

  if (OUT_REG == 0) begin : g_direct
    assign dout   = d1;
    assign dvalid = v1;
    assign coll   = c1;
  end else begin : g_outreg
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2;
    logic                  c2;

    // Second stage: forward only completed reads so dout keeps its last value.
    always_ff @(posedge clk) begin
      if (rst) begin
        d2 <= '0;
        v2 <= 1'b0;
        c2 <= 1'b0;
      end else begin
        v2 <= v1;
        c2 <= c1;
        if (v1) d2 <= d1;
      end
    end

    assign dout   = d2;
    assign dvalid = v2;
    assign coll   = c2;
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM behavioural model with lane masks, a defined
// read-during-write policy and a post-reset clear sweep gated by ready_o.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    LANE_WIDTH     = 8,
  parameter int                    OUT_REG        = 0,
  parameter int                    COLL_MODE      = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  output logic                  ready_o,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_LANES-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  coll_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % LANE_WIDTH) != 0 || OUT_REG > 1 || OUT_REG < 0 ||
      DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_params
    $fatal(1, "sram_1rw1r_param: illegal DATA_WIDTH/LANE_WIDTH/OUT_REG combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic wr_en;
  logic rd0_req;
  logic rd1_req;
  logic coll_now;
  logic clear_we;

  logic [MAX_DATA_WIDTH-1:0] old_ext;
  logic [MAX_DATA_WIDTH-1:0] new_ext;
  logic [MAX_DATA_WIDTH-1:0] mask_ext;
  logic [MAX_DATA_WIDTH-1:0] merged_ext;
  logic [DATA_WIDTH-1:0]     rd1_word;
  logic                      merge_unused;
  logic                      coll0_unused;

  // Requests are only honoured once the clear sweep has finished and reset is low.
  assign wr_en    = ready_o && !wb_rst_i && !csb0 && !web0;
  assign rd0_req  = ready_o && !wb_rst_i && !csb0 && web0;
  assign rd1_req  = ready_o && !wb_rst_i && !csb1;
  assign coll_now = wr_en && (|wmask0) && rd1_req && (addr0 == addr1);
  assign clear_we = (state == CLEAR) && !wb_rst_i;

  // Sequencer: reset, optional clear sweep, then normal operation with ready_o high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= RST;
      clr_cnt <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        RST: begin
          if (CLEAR_ON_RESET != 0) begin
            state <= CLEAR;
          end else begin
            state   <= RUN;
            ready_o <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state   <= RUN;
            ready_o <= 1'b1;
          end
        end
        RUN: begin
          ready_o <= 1'b1;
        end
        default: begin
          state   <= RST;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  // Array write: clear sweep has the port during CLEAR, masked lane writes in RUN.
  always_ff @(posedge wb_clk_i) begin
    if (clear_we) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (wr_en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wmask0[l]) mem[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Port 1 read word, optionally forwarding the colliding write's masked lanes.
  always_comb begin
    old_ext  = '0;
    new_ext  = '0;
    mask_ext = '0;
    old_ext[DATA_WIDTH-1:0] = mem[addr1];
    new_ext[DATA_WIDTH-1:0] = din0;
    mask_ext[NUM_LANES-1:0] = wmask0;
    merged_ext = lane_merge(old_ext, new_ext, mask_ext, LANE_WIDTH);
    rd1_word   = mem[addr1];
    if (COLL_MODE == COLL_NEW && coll_now) rd1_word = merged_ext[DATA_WIDTH-1:0];
  end

  assign merge_unused = ^merged_ext;

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe0 (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (rd0_req),
    .data_in (mem[addr0]),
    .coll_in (1'b0),
    .dout    (dout0),
    .dvalid  (dvalid0),
    .coll    (coll0_unused)
  );

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe1 (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (rd1_req),
    .data_in (rd1_word),
    .coll_in (coll_now),
    .dout    (dout1),
    .dvalid  (dvalid1),
    .coll    (coll_o)
  );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two 32-bit/16-word instances share stimulus
// (latency 1 + old-data collisions, latency 2 + write-through collisions)
// and are checked every cycle against a word-level model; a 64-bit/1024-word
// instance covers wide lanes and the top address.
module tb_sram_1rw1r_param;

  localparam logic [31:0] CLR = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [3:0]  addr0, addr1;
  logic [31:0] din0;

  logic        ready_a, dvalid0_a, dvalid1_a, coll_a;
  logic [31:0] dout0_a, dout1_a;
  logic        ready_b, dvalid0_b, dvalid1_b, coll_b;
  logic [31:0] dout0_b, dout1_b;

  logic        rst_c, csb0_c, web0_c, csb1_c;
  logic [3:0]  wmask0_c;
  logic [9:0]  addr0_c, addr1_c;
  logic [63:0] din0_c;
  logic        ready_c, dvalid0_c, dvalid1_c, coll_c;
  logic [63:0] dout0_c, dout1_c;

  int total = 0;
  int bad   = 0;

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8), .OUT_REG(0), .COLL_MODE(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .ready_o(ready_a),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dvalid0(dvalid0_a),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dvalid1(dvalid1_a), .coll_o(coll_a)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8), .OUT_REG(1), .COLL_MODE(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .ready_o(ready_b),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dvalid0(dvalid0_b),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dvalid1(dvalid1_b), .coll_o(coll_b)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(10), .LANE_WIDTH(16), .OUT_REG(0), .COLL_MODE(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(64'h0)
  ) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst_c), .ready_o(ready_c),
    .csb0(csb0_c), .web0(web0_c), .wmask0(wmask0_c), .addr0(addr0_c), .din0(din0_c),
    .dout0(dout0_c), .dvalid0(dvalid0_c),
    .csb1(csb1_c), .addr1(addr1_c), .dout1(dout1_c), .dvalid1(dvalid1_c), .coll_o(coll_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (shared word array) ----------------
  logic [31:0] mm [16];
  int          phase = 0;   // 0 = in reset, 1..16 = sweeping word phase-1 next, 17 = ready
  logic        ready_m = 1'b0;
  logic        ea_v0 = 0, ea_v1 = 0, ea_c = 0;
  logic [31:0] ea_d0 = '0, ea_d1 = '0;
  logic        eb_v0 = 0, eb_v1 = 0, eb_c = 0;
  logic [31:0] eb_d0 = '0, eb_d1 = '0;
  logic        pb_v0 = 0, pb_v1 = 0, pb_c = 0;
  logic [31:0] pb_d0 = '0, pb_d1 = '0;

  task automatic model_edge();
    logic        acc, rd0, wr, rd1, cl;
    logic [31:0] o0, o1, bm;
    acc = !rst && (phase == 17);
    rd0 = acc && !csb0 && web0;
    wr  = acc && !csb0 && !web0 && (wmask0 != 4'd0);
    rd1 = acc && !csb1;
    cl  = wr && rd1 && (addr0 == addr1);
    o0  = mm[addr0];
    o1  = mm[addr1];
    bm  = {{8{wmask0[3]}}, {8{wmask0[2]}}, {8{wmask0[1]}}, {8{wmask0[0]}}};
    if (rst) begin
      phase = 0;
      ea_v0 = 0; ea_v1 = 0; ea_c = 0; ea_d0 = '0; ea_d1 = '0;
      eb_v0 = 0; eb_v1 = 0; eb_c = 0; eb_d0 = '0; eb_d1 = '0;
      pb_v0 = 0; pb_v1 = 0; pb_c = 0; pb_d0 = '0; pb_d1 = '0;
    end else begin
      ea_v0 = rd0; if (rd0) ea_d0 = o0;
      ea_v1 = rd1; if (rd1) ea_d1 = o1;
      ea_c  = cl;
      eb_v0 = pb_v0; if (pb_v0) eb_d0 = pb_d0;
      eb_v1 = pb_v1; if (pb_v1) eb_d1 = pb_d1;
      eb_c  = pb_c;
      pb_v0 = rd0; pb_d0 = o0;
      pb_v1 = rd1; pb_d1 = cl ? ((o1 & ~bm) | (din0 & bm)) : o1;
      pb_c  = cl;
      if (wr) mm[addr0] = (mm[addr0] & ~bm) | (din0 & bm);
      if (phase >= 1 && phase <= 16) mm[phase-1] = CLR;
      if (phase < 17) phase++;
    end
    ready_m = (phase == 17);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_ab();
    chk("rdy_a",  64'(ready_a),   64'(ready_m));
    chk("dv0_a",  64'(dvalid0_a), 64'(ea_v0));
    chk("do0_a",  64'(dout0_a),   64'(ea_d0));
    chk("dv1_a",  64'(dvalid1_a), 64'(ea_v1));
    chk("do1_a",  64'(dout1_a),   64'(ea_d1));
    chk("coll_a", 64'(coll_a),    64'(ea_c));
    chk("rdy_b",  64'(ready_b),   64'(ready_m));
    chk("dv0_b",  64'(dvalid0_b), 64'(eb_v0));
    chk("do0_b",  64'(dout0_b),   64'(eb_d0));
    chk("dv1_b",  64'(dvalid1_b), 64'(eb_v1));
    chk("do1_b",  64'(dout1_b),   64'(eb_d1));
    chk("coll_b", 64'(coll_b),    64'(eb_c));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_ab();
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'd0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n, input logic chk_dv0);
    int n;
    n = 0;
    while (!ready_a && n < 40) begin
      step();
      n++;
      if (chk_dv0) chk("nr_dv0", 64'(dvalid0_a), 64'd0);
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int n;
    rst = 1'b1; idle(); addr0 = '0; addr1 = '0; din0 = '0;
    rst_c = 1'b1; csb0_c = 1'b1; web0_c = 1'b1; csb1_c = 1'b1;
    wmask0_c = '0; addr0_c = '0; addr1_c = '0; din0_c = '0;

    repeat (3) step();
    chk("rst_rdy_c", 64'(ready_c), 64'd0);
    chk("rst_do0_c", dout0_c, 64'd0);
    chk("rst_dv1_c", 64'(dvalid1_c), 64'd0);

    // clear sweep latency with port 0 reads attempted while not ready
    rst = 1'b0; rst_c = 1'b0;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd2;
    wait_ready("ready_lat", 17, 1'b1);
    idle();

    for (int i = 0; i < 16; i++) begin
      csb1 = 1'b0; addr1 = 4'(i);
      step();
      chk("clr_rd", 64'(dout1_a), 64'(CLR));
    end
    idle();
    step();

    // reset in the middle of the sweep (cnt = 7)
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (8) step();
    rst = 1'b1; step();
    rst = 1'b0;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd4;
    wait_ready("ready_restart", 17, 1'b1);
    idle();

    // byte masking
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 32'h11223344; wmask0 = 4'b1111;
    step();
    din0 = 32'hAABBCCDD; wmask0 = 4'b0101;
    step();
    web0 = 1'b1; wmask0 = 4'd0;
    step();
    chk("mask_l1", 64'(dout0_a), 64'h11BB33DD);
    chk("mask_l1_v", 64'(dvalid0_a), 64'd1);
    chk("mask_l2_early", 64'(dvalid0_b), 64'd0);
    idle();
    step();
    chk("mask_l2", 64'(dout0_b), 64'h11BB33DD);
    chk("mask_l2_v", 64'(dvalid0_b), 64'd1);

    // collisions
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'h0; wmask0 = 4'b1111;
    step();
    din0 = 32'hFFFFFFFF; wmask0 = 4'b0011; csb1 = 1'b0; addr1 = 4'd5;
    step();
    chk("coll_old_d", 64'(dout1_a), 64'h0);
    chk("coll_old_f", 64'(coll_a), 64'd1);
    idle();
    step();
    chk("coll_new_d", 64'(dout1_b), 64'h0000FFFF);
    chk("coll_new_f", 64'(coll_b), 64'd1);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'hFFFFFFFF; wmask0 = 4'b0000;
    csb1 = 1'b0; addr1 = 4'd5;
    step();
    chk("nocoll_f", 64'(coll_a), 64'd0);
    chk("nocoll_d", 64'(dout1_a), 64'h0000FFFF);
    idle();
    step();
    chk("nocoll_fb", 64'(coll_b), 64'd0);

    // back-to-back port 1 reads, then hold
    for (int i = 1; i <= 3; i++) begin
      csb1 = 1'b0; addr1 = 4'(i);
      step();
      chk("pipe_v", 64'(dvalid1_a), 64'd1);
      chk("pipe_d", 64'(dout1_a), (i == 3) ? 64'h11BB33DD : 64'(CLR));
    end
    idle();
    step();
    chk("hold_v", 64'(dvalid1_a), 64'd0);
    chk("hold_d", 64'(dout1_a), 64'h11BB33DD);
    step();
    chk("hold_vb", 64'(dvalid1_b), 64'd0);
    chk("hold_db", 64'(dout1_b), 64'h11BB33DD);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 249) == 0);
      csb0   = 1'($urandom_range(0, 1));
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom);
      addr0  = 4'($urandom);
      din0   = $urandom;
      csb1   = 1'($urandom_range(0, 1));
      addr1  = ($urandom_range(0, 1) == 1) ? addr0 : 4'($urandom);
      step();
    end
    rst = 1'b0; idle();
    n = 0;
    while (!ready_a && n < 40) begin step(); n++; end
    chk("rand_ready", 64'(ready_a), 64'd1);

    // wide configuration: 64-bit words, 16-bit lanes, 1024 words
    n = 0;
    while (!ready_c && n < 1200) begin step(); n++; end
    chk("c_ready", 64'(ready_c), 64'd1);
    csb0_c = 1'b0; web0_c = 1'b0; addr0_c = 10'd1023; din0_c = 64'h0123456789ABCDEF; wmask0_c = 4'b1111;
    step();
    din0_c = 64'hFFFFFFFFFFFFFFFF; wmask0_c = 4'b1000;
    step();
    web0_c = 1'b1; wmask0_c = 4'd0; csb1_c = 1'b0; addr1_c = 10'd0;
    step();
    chk("c_lane3", dout0_c, 64'hFFFF456789ABCDEF);
    chk("c_dv0", 64'(dvalid0_c), 64'd1);
    chk("c_addr0", dout1_c, 64'h0);
    chk("c_dv1", 64'(dvalid1_c), 64'd1);
    csb0_c = 1'b1; addr1_c = 10'd1023;
    step();
    chk("c_p1_top", dout1_c, 64'hFFFF456789ABCDEF);
    csb1_c = 1'b1;
    step();
    chk("c_hold_v", 64'(dvalid1_c), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
Synthesizable, parametrised behavioural model of a 1RW+1R SRAM for the user project area. It replaces the fixed 32x256 macro model.
- Single clock; all accesses on the rising edge.
- Configurable width, depth and byte-lane granularity.
- Optional output pipeline register.
- Defined read-during-write collision policy.
- Sequential memory clear after reset, with a ready handshake.
- Read data is held, never driven to X.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
ADDR_WIDTH, 8, address bits; DEPTH = 1 << ADDR_WIDTH.
LANE_WIDTH, 8, bits per write-mask lane; NUM_LANES = DATA_WIDTH / LANE_WIDTH.
OUT_REG, 0, 0 = read latency 1, 1 = read latency 2 (extra output register).
COLL_MODE, 0, 0 = port 1 returns old data on collision, 1 = write-through (port 1 returns the merged new word).
CLEAR_ON_RESET, 1, 1 = sweep every word to CLEAR_VALUE after reset.
CLEAR_VALUE, 0, fill value used by the clear sweep.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
ready_o  out  1  memory accepts requests
csb0  in  1  port 0 active-low select
web0  in  1  port 0 active-low write enable
wmask0  in  NUM_LANES  port 0 lane write mask
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 read data
dvalid0  out  1  port 0 read data valid pulse
csb1  in  1  port 1 active-low select
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 read data
dvalid1  out  1  port 1 read data valid pulse
coll_o  out  1  collision flag, aligned with dvalid1

Behaviour:
Reset:
- While wb_rst_i=1: ready_o=0, dout0=dout1=0, dvalid0=dvalid1=0, coll_o=0; the clear counter is set to 0; pipeline registers are cleared.
- The memory array itself is not reset directly.

State machine (states RST, CLEAR, RUN):
- RST -> CLEAR on the first cycle with wb_rst_i=0 when CLEAR_ON_RESET=1; RST -> RUN when CLEAR_ON_RESET=0.
- CLEAR: writes CLEAR_VALUE to mem[cnt] each cycle and increments cnt. At cnt=DEPTH-1 it goes to RUN; cnt wraps to 0 without overflow error.
- RUN: ready_o=1 from the first RUN cycle.
- wb_rst_i=1 in any state forces RST. A reset mid-clear restarts the sweep at address 0.
- While ready_o=0, csb0/csb1 are ignored: no write, no dvalid.

Request rules (RUN only):
- Write: csb0=0, web0=0. Lane i of mem[addr0] takes din0 lane i where wmask0[i]=1. Write becomes visible to reads issued in the next cycle.
- Port 0 read: csb0=0, web0=1. dout0 = mem[addr0], dvalid0=1, exactly 1+OUT_REG cycles after the request edge.
- Port 1 read: csb1=0. Same latency on dout1/dvalid1.
- Back-to-back reads are fully pipelined, one per cycle per port.
- When no read completes, dout holds its last value and dvalid=0.

Collision:
- Condition: port 0 write with any wmask bit set, port 1 read, addr0==addr1, same cycle.
- COLL_MODE=0: dout1 = pre-write word.
- COLL_MODE=1: dout1 = old word with the masked lanes replaced by din0.
- coll_o=1 in the same cycle as that dvalid1.
- A write with wmask0 all zero is a no-op and is not a collision.

Elaboration:
- DATA_WIDTH % LANE_WIDTH != 0 or OUT_REG>1 is a fatal elaboration error.

Decomposition:
- Package sram_pkg: state enum {RST, CLEAR, RUN}, COLL_OLD=0 / COLL_NEW=1 constants, lane-merge function (old, new, mask).
- Sub-module sram_rd_pipe, instantiated once per port: data/valid (and coll for port 1) capture plus the optional OUT_REG stage with hold-last-value.

Test Plan:
- Clear sweep: DATA_WIDTH=32, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5, release reset -> ready_o rises exactly 17 cycles later; port 1 reads of addresses 0..15 all return A5A5A5A5.
- Reset mid-clear: assert wb_rst_i at cnt=7 for 1 cycle -> ready_o stays 0 for a full 16-cycle sweep after release; reads ignored while not ready (dvalid0=0).
- Byte masking: write 32'h11223344 to addr 3 with wmask 4'b1111, then 32'hAABBCCDD with 4'b0101 -> port 0 read returns 32'h11BB33DD at latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
- Collision: mem[5]=32'h0, same cycle write 32'hFFFFFFFF mask 4'b0011 and port 1 read addr 5 -> COLL_MODE=0 gives dout1=0 with coll_o=1; COLL_MODE=1 gives dout1=32'h0000FFFF with coll_o=1. Same stimulus with mask 0 -> coll_o=0.
- Pipelining/hold: port 1 reads addr 1,2,3 on consecutive cycles, then idle -> dvalid1 high for 3 consecutive cycles with the correct words; dout1 afterwards holds mem[3] with dvalid1=0.
- Generalisation: DATA_WIDTH=64, LANE_WIDTH=16, ADDR_WIDTH=10 -> write mask 4'b1000 updates only bits 63:48 at addr 1023; address wrap is not aliased (addr 0 is unchanged).
